// File: rtl/keypad_emulator.sv
// Keypad emulator: answers a 4x4 column scan by closing one switch contact.
// Optional contact chatter model is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_emulator #(
   parameter int unsigned HOLD_CYCLES   = 2000,
   parameter int unsigned GAP_CYCLES    = 2000,
   parameter bit          ACTIVE_LOW    = 1'b0,
   parameter int unsigned BOUNCE_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   input  logic       abort,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic       busy,
   output logic       done
);

   localparam logic [23:0] HOLD_M1 = 24'(HOLD_CYCLES - 1);
   localparam logic [23:0] GAP_M1  = 24'(GAP_CYCLES - 1);

   if (BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= GAP_CYCLES) begin : g_bad_bounce
      $error("BOUNCE_CYCLES must be below HOLD_CYCLES and GAP_CYCLES");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS,
      S_RELEASE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [23:0] r_cnt;
   logic [23:0] w_cnt_nx;
   logic [1:0]  r_row;
   logic [1:0]  r_col;
   logic [1:0]  w_row_dec;
   logic [1:0]  w_col_dec;
   logic        r_ready;
   logic        r_busy;
   logic        w_accept;
   logic        w_contact;
   logic [3:0]  w_col;
   logic [3:0]  w_row;

   // Switch matrix layout: row-major, four keys per row
   always_comb begin
      w_row_dec = 2'd0;
      w_col_dec = 2'd0;
      case (key_code)
         4'h1: begin w_row_dec = 2'd0; w_col_dec = 2'd0; end
         4'h2: begin w_row_dec = 2'd0; w_col_dec = 2'd1; end
         4'h3: begin w_row_dec = 2'd0; w_col_dec = 2'd2; end
         4'hA: begin w_row_dec = 2'd0; w_col_dec = 2'd3; end
         4'h4: begin w_row_dec = 2'd1; w_col_dec = 2'd0; end
         4'h5: begin w_row_dec = 2'd1; w_col_dec = 2'd1; end
         4'h6: begin w_row_dec = 2'd1; w_col_dec = 2'd2; end
         4'hB: begin w_row_dec = 2'd1; w_col_dec = 2'd3; end
         4'h7: begin w_row_dec = 2'd2; w_col_dec = 2'd0; end
         4'h8: begin w_row_dec = 2'd2; w_col_dec = 2'd1; end
         4'h9: begin w_row_dec = 2'd2; w_col_dec = 2'd2; end
         4'hC: begin w_row_dec = 2'd2; w_col_dec = 2'd3; end
         4'hF: begin w_row_dec = 2'd3; w_col_dec = 2'd0; end
         4'h0: begin w_row_dec = 2'd3; w_col_dec = 2'd1; end
         4'hE: begin w_row_dec = 2'd3; w_col_dec = 2'd2; end
         default: begin w_row_dec = 2'd3; w_col_dec = 2'd3; end
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && key_valid && r_ready;

   always_comb begin
      w_next   = r_state;
      w_cnt_nx = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next   = S_PRESS;
               w_cnt_nx = HOLD_M1;
            end
         end
         S_PRESS: begin
            if (r_cnt == 24'd0 || abort) begin
               w_next   = S_RELEASE;
               w_cnt_nx = GAP_M1;
            end else begin
               w_cnt_nx = r_cnt - 24'd1;
            end
         end
         S_RELEASE: begin
            if (r_cnt == 24'd0) begin
               w_next = S_IDLE;
            end else begin
               w_cnt_nx = r_cnt - 24'd1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 24'd0;
         r_row   <= 2'd0;
         r_col   <= 2'd0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nx;
         r_ready <= (w_next == S_IDLE);
         r_busy  <= (w_next != S_IDLE);
         if (w_accept) begin
            r_row <= w_row_dec;
            r_col <= w_col_dec;
         end
      end
   end

`ifdef KEYPAD_BOUNCE_EN
   localparam logic [23:0] HOLD_WIN = 24'(HOLD_CYCLES - BOUNCE_CYCLES);
   localparam logic [23:0] GAP_WIN  = 24'(GAP_CYCLES - BOUNCE_CYCLES);

   logic [15:0] r_lfsr;
   logic        w_fb;
   logic        w_win;

   assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
      end
   end

   // Counter runs down, so the opening cycles of a phase sit at the top
   assign w_win = ((r_state == S_PRESS) && (r_cnt >= HOLD_WIN)) ||
                  ((r_state == S_RELEASE) && (r_cnt >= GAP_WIN));
   assign w_contact = w_win ? r_lfsr[0] : (r_state == S_PRESS);
`else
   assign w_contact = (r_state == S_PRESS);
`endif

   assign w_col = ACTIVE_LOW ? ~col_in : col_in;

   always_comb begin
      w_row = 4'h0;
      if (w_contact && w_col[r_col]) begin
         w_row[r_row] = 1'b1;
      end
   end

   assign row_out   = ACTIVE_LOW ? ~w_row : w_row;
   assign key_ready = r_ready;
   assign busy      = r_busy;
   assign done      = (r_state == S_RELEASE) && (r_cnt == 24'd0);

endmodule
